pal_cfg_loader: RTL
===================

# pal_cfg_loader

Configuration sequencer for the PAL fabric. It accepts the configuration bitstream as bytes over a valid/ready handshake and serializes it LSB-first into the PAL's serial `cfg` shift chain, issuing one shift-enable per bit. It counts exactly `CFG_BITS` bits, then asserts the apply/enable level that makes the fabric take the new configuration. It sits between a byte-wide host port (SPI/UART front end or the project IO pins) and the PAL's `cfg`/`en` inputs.

## Interface
- `CFG_BITS`, default 598, total bits in the PAL configuration chain (8 inputs, 26 product terms, 7 outputs); must be ≥ 1.
- `CNT_W`, default `$clog2(CFG_BITS+1)`, width of the internal bit counter; derived, not overridden.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `res_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new load; sampled in IDLE or APPLY only.
- `abort`  in  1  cancel a load in progress; has priority over every other input.
- `byte_valid`  in  1  host has a config byte on `byte_data`.
- `byte_data`  in  8  config byte; bit 0 is shifted first.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `cfg_out`  out  1  serial config bit to the PAL `cfg` input.
- `cfg_shift`  out  1  the PAL shift chain advances one bit on this clock edge.
- `cfg_apply`  out  1  level to the PAL `en` input; high means the loaded configuration is live.
- `busy`  out  1  a load is in progress (WAIT_BYTE or SHIFT).
- `done`  out  1  one-cycle pulse when the final bit has been shifted.

## Operation
- States:
  - IDLE: reset state.
  - WAIT_BYTE: `byte_ready` = 1; waits for a byte.
  - SHIFT: streams the held byte into the chain.
  - APPLY: holds `cfg_apply` = 1.
- IDLE or APPLY, with `start` = 1 and `abort` = 0:
  - Next state is WAIT_BYTE.
  - Bit counter clears to 0.
  - `cfg_apply` drops to 0 on the same edge.
- WAIT_BYTE, with `byte_valid` && `byte_ready`:
  - Latch `byte_data` into the shift register.
  - Set the byte-bit index to 0.
  - Next state is SHIFT.
- SHIFT:
  - Each cycle: `cfg_shift` = 1, `cfg_out` = `shreg[0]`.
  - At each edge: shift the register right by one and increment both the bit counter and the byte-bit index.
  - When the bit counter reaches `CFG_BITS`, go to APPLY. This happens even mid-byte; the remaining bits of that byte are discarded.
  - Otherwise, after the 8th bit of the byte, return to WAIT_BYTE.
- APPLY:
  - `cfg_apply` = 1 and `done` = 1 on the first cycle only.
  - Remains in APPLY until `start` or `abort`.
- `abort` = 1 in any state:
  - Next state is IDLE.
  - `cfg_apply` = 0 and counters clear.
  - No `done` pulse.
  - The chain holds a partial configuration; the fabric stays disabled.
- `start` in WAIT_BYTE or SHIFT is ignored; a load never restarts mid-stream.
- `start` and `abort` asserted together: `abort` wins and the state is IDLE.
- `byte_valid` outside WAIT_BYTE is ignored; the byte is not consumed.
- `cfg_out` = 0 whenever `cfg_shift` = 0.
- `busy` = 1 in WAIT_BYTE and SHIFT only.

## Timing
- Reset (`res_n` = 0, asynchronous):
  - State is IDLE.
  - `byte_ready`, `cfg_out`, `cfg_shift`, `cfg_apply`, `busy` and `done` are all 0.
  - Counters and shift register are 0.
- `start` sampled at edge t: `byte_ready` = 1 from cycle t+1.
- Byte accepted at edge a: its bit 0 appears on `cfg_out`, with `cfg_shift` = 1, during cycle a+1.
- A full byte occupies cycles a+1 … a+8. `byte_ready` returns in cycle a+9 at the earliest.
- Sustained throughput is 9 cycles per byte when the host holds `byte_valid` high.
- Final bit shifted at edge f: `done` = 1 and `cfg_apply` = 1 in cycle f+1. `done` is 0 from cycle f+2.
- With default `CFG_BITS` = 598:
  - 75 bytes are required; the last byte contributes bits 0..5 only.
  - Minimum load time is start + 75×9 − 2 + 1 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- The counter never exceeds `CFG_BITS`; no wrap-around.

## Test plan
- Reset mid-SHIFT (assert `res_n` = 0 asynchronously) → all outputs 0 immediately; state IDLE; next `start` behaves normally.
- `CFG_BITS` = 12, `start`, then bytes 0xA5 and 0x3C, each presented as soon as `byte_ready` is high:
  - `cfg_out` under `cfg_shift` = 1 reads 1,0,1,0,0,1,0,1,0,0,1,1.
  - Exactly 12 `cfg_shift` cycles occur.
  - `done` pulses once and `cfg_apply` = 1 in the cycle after the 12th shift.
- Host backpressure, `CFG_BITS` = 16: `byte_valid` held low for 5 cycles in WAIT_BYTE → `cfg_shift` = 0 and `busy` = 1 throughout; the load resumes with no lost or duplicated bits.
- `abort` in SHIFT at bit 5 of byte 2 → next cycle IDLE, `busy` = 0, `cfg_apply` = 0, no `done`.
- Simultaneous `start` and `abort` in APPLY → IDLE with `cfg_apply` = 0.
- `start` during SHIFT → ignored; the bit count and `done` timing are unchanged.
- Default `CFG_BITS` = 598, 75 bytes of 0xFF → exactly 598 `cfg_shift` pulses.
- Then `start` again from APPLY → `cfg_apply` falls the next cycle and `byte_ready` rises.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: byte-wide host port to PAL serial configuration chain.
// Bytes arrive over valid/ready and are shifted into the chain LSB-first,
// one shift-enable per bit. After CFG_BITS bits the apply level is raised.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | reset / aborted; fabric disabled, waiting for start
// S_WAIT_BYTE | byte_ready high, waiting for the next host byte
// S_SHIFT     | streaming the held byte into the chain, one bit/cycle
// S_APPLY     | full configuration loaded, cfg_apply held high
module pal_cfg_loader #(
  parameter int CFG_BITS = 598
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       start,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       cfg_out,
  output logic       cfg_shift,
  output logic       cfg_apply,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CFG_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SHIFT,
    S_APPLY
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shreg;
  logic             r_byte_ready;
  logic             r_cfg_out;
  logic             r_cfg_shift;
  logic             r_cfg_apply;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_bit;

  // Bit counter look-ahead: the edge that shifts the final chain bit.
  always_comb begin
    w_cnt_nxt  = r_cnt + CNT_W'(1);
    w_last_bit = (w_cnt_nxt == LP_LAST);
  end

  // Sequencer with registered outputs; cfg_out always mirrors r_shreg[0]
  // while shifting, and the counter stops at CFG_BITS.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_byte_ready <= 1'b0;
      r_cfg_out    <= 1'b0;
      r_cfg_shift  <= 1'b0;
      r_cfg_apply  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        r_idx        <= '0;
        r_shreg      <= '0;
        r_byte_ready <= 1'b0;
        r_cfg_out    <= 1'b0;
        r_cfg_shift  <= 1'b0;
        r_cfg_apply  <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_APPLY: begin
            if (start) begin
              r_state      <= S_WAIT_BYTE;
              r_cnt        <= '0;
              r_idx        <= '0;
              r_cfg_apply  <= 1'b0;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          S_WAIT_BYTE: begin
            if (byte_valid && r_byte_ready) begin
              r_state      <= S_SHIFT;
              r_shreg      <= byte_data;
              r_idx        <= '0;
              r_cfg_out    <= byte_data[0];
              r_cfg_shift  <= 1'b1;
              r_byte_ready <= 1'b0;
            end
          end
          S_SHIFT: begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= r_idx + 3'd1;
            r_shreg <= {1'b0, r_shreg[7:1]};
            if (w_last_bit) begin
              // Remaining bits of a partial final byte are dropped here.
              r_state     <= S_APPLY;
              r_cfg_shift <= 1'b0;
              r_cfg_out   <= 1'b0;
              r_cfg_apply <= 1'b1;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
            end else if (r_idx == 3'd7) begin
              r_state      <= S_WAIT_BYTE;
              r_cfg_shift  <= 1'b0;
              r_cfg_out    <= 1'b0;
              r_byte_ready <= 1'b1;
            end else begin
              r_cfg_out <= r_shreg[1];
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign cfg_out    = r_cfg_out;
  assign cfg_shift  = r_cfg_shift;
  assign cfg_apply  = r_cfg_apply;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
